irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised interrupt controller; successor to the single-line key_interrupt input on the CPU top level.
- Gathers NUM_CH asynchronous interrupt lines and synchronises them.
- Latches lines as pending, masks them, and presents one prioritised request (irq, irq_id) to the processor with an ack/EOI handshake.
- Control/status registers are memory-mapped onto the dmem bus (wren/address/data/q) alongside RAM.

Parameters:
- NUM_CH, 8, number of interrupt lines, 1..32.
- ADDR_W, 12, dmem address width.
- BASE_ADDR, 12'hF00, base address of the register window (8 words).
- SYNC_STAGES, 2, synchroniser flops per line, >=2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_CH  raw asynchronous interrupt lines.
- wren  in  1  dmem write enable.
- address  in  ADDR_W  dmem word address.
- data_in  in  32  dmem write data.
- q  out  32  register read data.
- irq  out  1  interrupt request to processor.
- irq_id  out  5  index of the requested channel.
- irq_ack  in  1  processor accepts the request (1-cycle pulse).

Behaviour:
- Reset (reset=0, async): all flops cleared. PENDING, MASK, EDGE_SEL = 0; FSM in IDLE; irq=0, irq_id=0, q=0.
- Window decode: a register is selected when address[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]; offset = address[2:0]. Unselected addresses produce no writes and q=0.
- Register map:
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: R/W; 1 = enabled.
  - 2 EDGE_SEL: R/W; 1 = rising-edge mode, 0 = level mode.
  - 3 STATUS: read; {state[1:0] in bits 9:8, irq_id in 4:0}.
  - 4 EOI: write any value.
  - 5 TSTAMP: see Optional Feature.
  - 6, 7: read 0.
- Bits >= NUM_CH read 0 and ignore writes.
- Reads: q is registered; data appears 1 cycle after address is presented.
- Synchroniser: each irq_in bit passes SYNC_STAGES flops to give s[i]. Edge detect: rise[i] = s[i] & ~s_d[i].
- Pending update, evaluated per cycle per bit:
  - Edge mode: a set from rise[i] wins over a simultaneous W1C clear or ack clear.
  - Level mode: pending[i] = s[i] every cycle; W1C and ack have no lasting effect while the line is high.
- Candidate set: cand = PENDING & MASK. Winner = lowest set index (fixed priority, channel 0 highest).
- FSM:
  - IDLE: if cand != 0, latch irq_id = winner and go REQ.
  - REQ: irq=1, irq_id held stable even if PENDING/MASK change. On irq_ack: clear pending[irq_id] (edge mode), go SERVICE. If the channel becomes masked before ack, stay in REQ; the latched id remains valid.
  - SERVICE: irq=0; new requests are held pending. A write to EOI returns to IDLE. The next request, if any, is evaluated in IDLE on the following cycle, so irq re-asserts 2 cycles after the EOI write.
  - EOI writes in IDLE or REQ are ignored.
  - irq_ack outside REQ is ignored.
- Latency: edge on irq_in to irq high is SYNC_STAGES+2 cycles when IDLE and unmasked (synchroniser, edge/pending, IDLE->REQ).
- Mid-operation reset returns everything to the reset values immediately; there is no stale irq after deassertion.

Optional Feature:
- Macro: IRQ_TIMESTAMP_EN.
- With the macro defined: a free-running 32-bit cycle counter (reset 0, wraps 32'hFFFFFFFF->0) is captured into TSTAMP on every IDLE->REQ transition. TSTAMP is readable at offset 5; writes are ignored.
- Without the macro: no counter or TSTAMP flops exist, and offset 5 reads 0.

Test Plan:
- Reset/readback: hold reset=0, then release; read offsets 0-5 -> all 0, irq=0. Write MASK=0xFF, EDGE_SEL=0x0F -> read back 0xFF, 0x0F with q one cycle after address.
- Single edge: MASK=0x08, EDGE_SEL=0x08, pulse irq_in[3] for 1 cycle -> irq=1, irq_id=3 after 4 cycles. Ack -> PENDING=0, irq=0. EOI write -> STATUS state=IDLE.
- Priority/hold: pulse irq_in[5] and irq_in[2] together (both unmasked, edge) -> irq_id=2. Ack, EOI -> irq re-asserts 2 cycles later with irq_id=5.
- Set vs clear: W1C of bit 1 on the same cycle as rise[1] -> PENDING bit 1 stays 1. Masked channel: irq_in[7] with MASK bit 7 = 0 -> PENDING bit 7 = 1, irq stays 0; setting MASK bit 7 -> irq_id=7.
- Level mode: EDGE_SEL=0, irq_in[0] held high -> W1C of bit 0 has no effect and the request repeats after each EOI. Drop irq_in[0] -> PENDING bit 0 clears SYNC_STAGES+1 cycles later.
- Async reset in REQ: assert reset=0 mid-cycle while irq=1 -> irq=0 immediately, all registers 0. With IRQ_TIMESTAMP_EN: request taken at cycle 100 after reset -> TSTAMP reads that capture cycle (exact value checked by the bench counter).

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt controller: synchronised lines, pending/mask/edge-select registers on the dmem bus,
// and one fixed-priority request with an ack/EOI handshake. Define IRQ_TIMESTAMP_EN for TSTAMP.
module irq_controller #(
  parameter int                NUM_CH      = 8,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'hF00,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       q,
  output logic              irq,
  output logic [4:0]        irq_id,
  input  logic              irq_ack
);
  localparam logic [31:0] CH_MASK = 32'((64'd1 << NUM_CH) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  state_t state;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s_d;
  logic [31:0]       s, rise;
  logic [31:0]       pending, mask, edge_sel;
  logic [31:0]       pending_nxt, cand, ack_clr, w1c;
  logic [31:0]       rd_data, tstamp_rd;
  logic [4:0]        win_id;
  logic              sel;
  logic [2:0]        offset;
  logic              wr_pending, wr_mask, wr_edge, wr_eoi;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = 32'(sync_q[SYNC_STAGES-1]);
  assign rise = s & ~32'(s_d);

  assign sel        = (address[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign offset     = address[2:0];
  assign wr_pending = wren && sel && (offset == 3'd0);
  assign wr_mask    = wren && sel && (offset == 3'd1);
  assign wr_edge    = wren && sel && (offset == 3'd2);
  assign wr_eoi     = wren && sel && (offset == 3'd4);

  // Edge-mode bits: a new rise beats any clear in the same cycle. Level-mode bits follow the line.
  always_comb begin
    ack_clr = '0;
    if (state == REQ && irq_ack) ack_clr[irq_id] = 1'b1;
    w1c = wr_pending ? data_in : '0;
    pending_nxt = ((edge_sel & ((pending & ~(w1c | ack_clr)) | rise)) | (~edge_sel & s)) & CH_MASK;
    cand = pending & mask;
    win_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand[i]) win_id = 5'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr_mask) mask <= data_in & CH_MASK;
      if (wr_edge) edge_sel <= data_in & CH_MASK;
    end
  end

  // Handshake: irq stays high with irq_id frozen until a one-cycle irq_ack; the controller then
  // stays quiet in SERVICE until software writes EOI, and re-arbitrates from IDLE the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: if (cand != '0) begin
          state  <= REQ;
          irq    <= 1'b1;
          irq_id <= win_id;
        end
        REQ: if (irq_ack) begin
          state <= SERVICE;
          irq   <= 1'b0;
        end
        SERVICE: if (wr_eoi) state <= IDLE;
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_TIMESTAMP_EN
  logic [31:0] cycle_cnt, tstamp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      tstamp    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == IDLE && cand != '0) tstamp <= cycle_cnt;
    end
  end

  assign tstamp_rd = tstamp;
`else
  assign tstamp_rd = 32'd0;
`endif

  always_comb begin
    rd_data = '0;
    case (offset)
      3'd0:    rd_data = pending;
      3'd1:    rd_data = mask;
      3'd2:    rd_data = edge_sel;
      3'd3:    rd_data = {22'd0, state, 3'd0, irq_id};
      3'd5:    rd_data = tstamp_rd;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= sel ? rd_data : '0;
  end
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed handshake sequences,
// and randomized edge-mode rounds checked against a pending-set / priority-order model.
module tb_irq_controller;
  localparam int                NUM_CH = 8;
  localparam int                ADDR_W = 12;
  localparam logic [ADDR_W-1:0] BASE   = 12'hF00;
  localparam int                SYNC   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] irq_in = '0;
  logic              wren = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       data_in = '0;
  logic [31:0]       q;
  logic              irq;
  logic [4:0]        irq_id;
  logic              irq_ack = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned tb_cyc;
  logic [4:0]  exp_q[$];

  typedef struct {
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } rw_vec_t;
  rw_vec_t rw_tab [11];

  irq_controller #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .wren(wren), .address(address),
    .data_in(data_in), .q(q), .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  // clock / reset
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [31:0] val);
    address = {BASE[ADDR_W-1:3], off};
    wren    = 1'b1;
    data_in = val;
    tick();
    wren    = 1'b0;
    data_in = '0;
    address = '0;
  endtask

  task automatic reg_read(input logic [2:0] off, output logic [31:0] val);
    address = {BASE[ADDR_W-1:3], off};
    tick();
    val     = q;
    address = '0;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] bits);
    irq_in = bits;
    tick();
    irq_in = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("irq_wait", 32'(irq), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  m, p, w, model_pend;
    logic [4:0]  e;
    int unsigned exp_ts;

    rw_tab[0]  = '{3'd1, 32'h0000_00FF, 32'h0000_00FF};
    rw_tab[1]  = '{3'd2, 32'h0000_000F, 32'h0000_000F};
    rw_tab[2]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_00FF};
    rw_tab[3]  = '{3'd2, 32'hA5A5_A5A5, 32'h0000_00A5};
    rw_tab[4]  = '{3'd1, 32'h0000_0000, 32'h0000_0000};
    rw_tab[5]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    rw_tab[6]  = '{3'd3, 32'h0000_0303, 32'h0000_0000};
    rw_tab[7]  = '{3'd6, 32'h0000_1234, 32'h0000_0000};
    rw_tab[8]  = '{3'd7, 32'hDEAD_BEEF, 32'h0000_0000};
    rw_tab[9]  = '{3'd5, 32'h0000_1234, 32'h0000_0000};
    rw_tab[10] = '{3'd2, 32'h0000_0000, 32'h0000_0000};

    // reset and readback
    reset = 1'b0;
    ticks(3);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_id", 32'(irq_id), 32'd0);
    check("reset_q", q, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reg_read(3'(i), rd);
      check($sformatf("reset_reg%0d", i), rd, 32'd0);
    end
    check("reset_irq_after", 32'(irq), 32'd0);

    // register table
    for (int i = 0; i < 11; i++) begin
      reg_write(rw_tab[i].off, rw_tab[i].wdata);
      reg_read(rw_tab[i].off, rd);
      check($sformatf("rw_tab%0d", i), rd, rw_tab[i].exp);
    end

    // out-of-window accesses
    address = 12'hF09; wren = 1'b1; data_in = 32'hFF; tick();
    address = 12'h701; tick();
    wren = 1'b0; data_in = '0; address = 12'hF09; tick();
    check("unsel_read_q", q, 32'd0);
    address = '0;
    reg_read(3'd1, rd);
    check("unsel_no_write", rd, 32'd0);

    // single edge
    reg_write(3'd1, 32'h08);
    reg_write(3'd2, 32'h08);
    pulse(8'h08);
    ticks(2);
    check("edge_latency_early", 32'(irq), 32'd0);
    tick();
    check("edge_irq", 32'(irq), 32'd1);
    check("edge_id", 32'(irq_id), 32'd3);
    ack();
    check("ack_irq_low", 32'(irq), 32'd0);
    reg_read(3'd0, rd);
    check("ack_pending_clear", rd, 32'd0);
    reg_read(3'd3, rd);
    check("status_service", rd, 32'h203);
    reg_write(3'd4, 32'd0);
    reg_read(3'd3, rd);
    check("status_idle", rd, 32'h003);

    // priority and hold
    reg_write(3'd1, 32'h24);
    reg_write(3'd2, 32'h24);
    pulse(8'h24);
    ticks(3);
    check("prio_irq", 32'(irq), 32'd1);
    check("prio_id", 32'(irq_id), 32'd2);
    ack();
    reg_write(3'd4, 32'd0);
    check("eoi_gap", 32'(irq), 32'd0);
    tick();
    check("reassert_irq", 32'(irq), 32'd1);
    check("reassert_id", 32'(irq_id), 32'd5);
    reg_write(3'd4, 32'd0);
    reg_read(3'd3, rd);
    check("eoi_in_req_ignored", rd, 32'h105);
    ack();
    reg_write(3'd4, 32'd0);
    ack();
    reg_read(3'd3, rd);
    check("ack_in_idle_ignored", rd, 32'h005);

    // set beats simultaneous W1C
    reg_write(3'd1, 32'h00);
    reg_write(3'd2, 32'h82);
    irq_in = 8'h02;
    ticks(2);
    reg_write(3'd0, 32'h02);
    reg_read(3'd0, rd);
    check("set_beats_w1c", rd, 32'h02);
    irq_in = '0;
    reg_write(3'd0, 32'h02);
    reg_read(3'd0, rd);
    check("w1c_clear", rd, 32'h00);

    // masked channel
    pulse(8'h80);
    ticks(4);
    check("masked_no_irq", 32'(irq), 32'd0);
    reg_read(3'd0, rd);
    check("masked_pending", rd, 32'h80);
    reg_write(3'd1, 32'h80);
    tick();
    check("unmask_irq", 32'(irq), 32'd1);
    check("unmask_id", 32'(irq_id), 32'd7);
    ack();
    reg_write(3'd4, 32'd0);

    // level mode
    reg_write(3'd2, 32'h00);
    reg_write(3'd1, 32'h01);
    irq_in = 8'h01;
    ticks(4);
    check("level_irq", 32'(irq), 32'd1);
    check("level_id", 32'(irq_id), 32'd0);
    reg_write(3'd0, 32'h01);
    reg_read(3'd0, rd);
    check("level_w1c_no_effect", rd, 32'h01);
    ack();
    reg_read(3'd0, rd);
    check("level_ack_no_effect", rd, 32'h01);
    reg_write(3'd4, 32'd0);
    tick();
    check("level_repeat_irq", 32'(irq), 32'd1);
    check("level_repeat_id", 32'(irq_id), 32'd0);
    ack();
    irq_in  = '0;
    address = {BASE[ADDR_W-1:3], 3'd0};
    ticks(SYNC + 1);
    check("level_hold", q, 32'h01);
    tick();
    check("level_drop", q, 32'h00);
    address = '0;
    reg_write(3'd4, 32'd0);
    ticks(2);
    check("level_quiet", 32'(irq), 32'd0);

    // async reset while requesting
    reg_write(3'd2, 32'h08);
    reg_write(3'd1, 32'h08);
    pulse(8'h08);
    address = {BASE[ADDR_W-1:3], 3'd1};
    ticks(3);
    check("pre_reset_irq", 32'(irq), 32'd1);
    check("pre_reset_q", q, 32'h08);
    #3;
    reset = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'd0);
    check("async_id", 32'(irq_id), 32'd0);
    check("async_q", q, 32'd0);
    address = '0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reg_read(3'(i), rd);
      check($sformatf("post_reset_reg%0d", i), rd, 32'd0);
    end

    // timestamp capture near cycle 100
    reg_write(3'd1, 32'h01);
    reg_write(3'd2, 32'h01);
    while (tb_cyc < 96) tick();
    pulse(8'h01);
    wait_irq(10);
`ifdef IRQ_TIMESTAMP_EN
    exp_ts = tb_cyc - 1;
`else
    exp_ts = 0;
`endif
    reg_read(3'd5, rd);
    check("tstamp", rd, 32'(exp_ts));
    ack();
    reg_write(3'd4, 32'd0);

    // randomized edge-mode rounds
    model_pend = '0;
    reg_write(3'd2, 32'hFF);
    for (int r = 0; r < 20; r++) begin
      m = 8'($urandom_range(0, 255));
      p = 8'($urandom_range(1, 255));
      reg_write(3'd1, 32'd0);
      pulse(p);
      ticks(3);
      model_pend = model_pend | p;
      reg_write(3'd1, 32'(m));
      for (int i = 0; i < NUM_CH; i++) begin
        if (model_pend[i] && m[i]) exp_q.push_back(5'(i));
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        wait_irq(8);
        check("rand_id", 32'(irq_id), 32'(e));
        ack();
        model_pend[e] = 1'b0;
        reg_write(3'd4, 32'd0);
      end
      ticks(3);
      check("rand_idle", 32'(irq), 32'd0);
      reg_read(3'd0, rd);
      check("rand_pending", rd, 32'(model_pend));
      w = 8'($urandom_range(0, 255));
      reg_write(3'd0, 32'(w));
      model_pend = model_pend & ~w;
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
